// File: rtl/mem_access_stage_pkg.sv
// Shared MIPS opcode/funct constants, access-kind enums and the MEM-stage decoder.
package mem_access_stage_pkg;

  localparam int T_NEW_W = 3;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_JALR    = 6'h09;

  typedef enum logic [2:0] {LD_NONE, LD_B, LD_BU, LD_H, LD_HU, LD_W} ld_kind_e;
  typedef enum logic [1:0] {ST_NONE, ST_B, ST_H, ST_W} st_kind_e;

  typedef struct packed {
    ld_kind_e ld;
    st_kind_e st;
    logic     link;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d.ld   = LD_NONE;
    d.st   = ST_NONE;
    d.link = 1'b0;
    case (ins[31:26])
      OP_LB:      d.ld = LD_B;
      OP_LBU:     d.ld = LD_BU;
      OP_LH:      d.ld = LD_H;
      OP_LHU:     d.ld = LD_HU;
      OP_LW:      d.ld = LD_W;
      OP_SB:      d.st = ST_B;
      OP_SH:      d.st = ST_H;
      OP_SW:      d.st = ST_W;
      OP_JAL:     d.link = 1'b1;
      OP_SPECIAL: d.link = (ins[5:0] == FN_JALR);
      default:    ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_ext.sv
// Picks the addressed byte/halfword lane out of the read word and sign/zero-extends it.
module mem_access_stage_load_ext
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  off,
  input  ld_kind_e    kind,
  input  logic [31:0] rdata,
  output logic [31:0] ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{off, 3'b000} +: 8];
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    ext    = '0;
    case (kind)
      LD_B:    ext = {{24{lane_b[7]}}, lane_b};
      LD_BU:   ext = {24'h0, lane_b};
      LD_H:    ext = {{16{lane_h[15]}}, lane_h};
      LD_HU:   ext = {16'h0, lane_h};
      LD_W:    ext = rdata;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-memory port, extends loads, forwards the M value and
// registers the M->W bundle (1-cycle latency, clr loads a bubble).
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter logic [31:0] LINK_OFF = 32'd8,
  parameter int          ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic [31:0]        M_Ins,
  input  logic [4:0]         M_TargetReg,
  input  logic [T_NEW_W-1:0] M_T_new,
  input  logic [31:0]        M_ALUAns,
  input  logic [31:0]        M_WriteData,
  input  logic [31:0]        M_PCAddr,
  output logic [ADDR_W-1:0]  DM_Addr,
  output logic [31:0]        DM_WData,
  output logic [3:0]         DM_ByteEn,
  input  logic [31:0]        DM_RData,
  output logic [31:0]        M_FwdData,
  output logic [31:0]        W_Ins,
  output logic [4:0]         W_TargetReg,
  output logic [T_NEW_W-1:0] W_T_new,
  output logic [31:0]        W_RegData,
  output logic [31:0]        W_PCAddr,
  output logic               W_AddrErr
);

  dec_t        dec;
  logic [1:0]  off;
  logic        misalign;
  logic [31:0] load_val;
  logic [31:0] wb_val;

  assign dec = decode(M_Ins);
  assign off = M_ALUAns[1:0];

  always_comb begin
    misalign = 1'b0;
    if (dec.ld == LD_W || dec.st == ST_W)
      misalign = (off != 2'b00);
    else if (dec.ld == LD_H || dec.ld == LD_HU || dec.st == ST_H)
      misalign = off[0];
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    DM_ByteEn = 4'b0000;
    DM_WData  = M_WriteData;
    case (dec.st)
      ST_W: DM_ByteEn = 4'b1111;
      ST_H: begin
        DM_ByteEn = 4'b0011 << off;
        DM_WData  = {2{M_WriteData[15:0]}};
      end
      ST_B: begin
        DM_ByteEn = 4'b0001 << off;
        DM_WData  = {4{M_WriteData[7:0]}};
      end
      default: ;
    endcase
    if (misalign)
      DM_ByteEn = 4'b0000;
  end

  assign DM_Addr   = {M_ALUAns[ADDR_W-1:2], 2'b00};
  assign M_FwdData = dec.link ? (M_PCAddr + LINK_OFF) : M_ALUAns;

  mem_access_stage_load_ext u_load_ext (
    .off   (off),
    .kind  (dec.ld),
    .rdata (DM_RData),
    .ext   (load_val)
  );

  assign wb_val = (dec.ld == LD_NONE) ? M_FwdData : (misalign ? 32'h0 : load_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      W_Ins       <= '0;
      W_TargetReg <= '0;
      W_T_new     <= '0;
      W_RegData   <= '0;
      W_PCAddr    <= '0;
      W_AddrErr   <= 1'b0;
    end else if (clr) begin
      W_Ins       <= '0;
      W_TargetReg <= '0;
      W_T_new     <= '0;
      W_RegData   <= '0;
      W_PCAddr    <= M_PCAddr;
      W_AddrErr   <= 1'b0;
    end else begin
      W_Ins       <= M_Ins;
      W_TargetReg <= M_TargetReg;
      W_T_new     <= (M_T_new != '0) ? M_T_new - 1'b1 : '0;
      W_RegData   <= wb_val;
      W_PCAddr    <= M_PCAddr;
      W_AddrErr   <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, async-reset sequence, and random
// instructions checked against a size/alignment-based reference model.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        clr;
  logic [31:0] M_Ins;
  logic [4:0]  M_TargetReg;
  logic [2:0]  M_T_new;
  logic [31:0] M_ALUAns;
  logic [31:0] M_WriteData;
  logic [31:0] M_PCAddr;
  logic [31:0] DM_Addr;
  logic [31:0] DM_WData;
  logic [3:0]  DM_ByteEn;
  logic [31:0] DM_RData;
  logic [31:0] M_FwdData;
  logic [31:0] W_Ins;
  logic [4:0]  W_TargetReg;
  logic [2:0]  W_T_new;
  logic [31:0] W_RegData;
  logic [31:0] W_PCAddr;
  logic        W_AddrErr;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .clr(clr),
    .M_Ins(M_Ins), .M_TargetReg(M_TargetReg), .M_T_new(M_T_new),
    .M_ALUAns(M_ALUAns), .M_WriteData(M_WriteData), .M_PCAddr(M_PCAddr),
    .DM_Addr(DM_Addr), .DM_WData(DM_WData), .DM_ByteEn(DM_ByteEn), .DM_RData(DM_RData),
    .M_FwdData(M_FwdData), .W_Ins(W_Ins), .W_TargetReg(W_TargetReg), .W_T_new(W_T_new),
    .W_RegData(W_RegData), .W_PCAddr(W_PCAddr), .W_AddrErr(W_AddrErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [31:0] I_LB   = 32'h8000_0000;
  localparam logic [31:0] I_LH   = 32'h8400_0000;
  localparam logic [31:0] I_LW   = 32'h8C00_0000;
  localparam logic [31:0] I_LBU  = 32'h9000_0000;
  localparam logic [31:0] I_LHU  = 32'h9400_0000;
  localparam logic [31:0] I_SB   = 32'hA000_0000;
  localparam logic [31:0] I_SH   = 32'hA400_0000;
  localparam logic [31:0] I_SW   = 32'hAC00_0000;
  localparam logic [31:0] I_JAL  = 32'h0C00_0000;
  localparam logic [31:0] I_JALR = 32'h0060_F809;

  typedef struct {
    logic        clr;
    logic [31:0] ins, alu, rt, pc, rdata;
    logic [4:0]  tr;
    logic [2:0]  tnew;
    logic        chk_wd;
    logic [3:0]  be;
    logic [31:0] wd, fwd, reg_val;
    logic [2:0]  wtnew;
    logic        err;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic [31:0] ins, alu, rt, pc, rdata,
                              input logic [4:0] tr, input logic [2:0] tnew, input logic cw,
                              input logic [3:0] be, input logic [31:0] wd, fwd, rv,
                              input logic [2:0] wtn, input logic err);
    vec_t v;
    v.clr = c; v.ins = ins; v.alu = alu; v.rt = rt; v.pc = pc; v.rdata = rdata;
    v.tr = tr; v.tnew = tnew; v.chk_wd = cw; v.be = be; v.wd = wd; v.fwd = fwd;
    v.reg_val = rv; v.wtnew = wtn; v.err = err;
    return v;
  endfunction

  // Reference: behaviour derived from access size and address alignment.
  function automatic vec_t model(input vec_t vin);
    vec_t v;
    int size, off;
    bit is_ld, is_st, sgn, link, aligned;
    logic [31:0] val;
    logic [5:0]  op;
    v = vin;
    op = v.ins[31:26];
    size = 0; is_ld = 0; is_st = 0; sgn = 0; link = 0;
    case (op)
      6'h20: begin is_ld = 1; size = 1; sgn = 1; end
      6'h21: begin is_ld = 1; size = 2; sgn = 1; end
      6'h23: begin is_ld = 1; size = 4; end
      6'h24: begin is_ld = 1; size = 1; end
      6'h25: begin is_ld = 1; size = 2; end
      6'h28: begin is_st = 1; size = 1; end
      6'h29: begin is_st = 1; size = 2; end
      6'h2b: begin is_st = 1; size = 4; end
      6'h03: link = 1;
      6'h00: link = (v.ins[5:0] == 6'd9);
      default: ;
    endcase
    off = int'(v.alu % 4);
    aligned = (size == 0) || (off % size == 0);
    v.be = (is_st && aligned) ? 4'(((1 << size) - 1) << off) : 4'h0;
    v.chk_wd = is_st;
    v.wd = 0;
    for (int i = 0; i < 4; i++)
      if (size != 0) v.wd = v.wd | (((v.rt >> (8 * (i % size))) & 32'hFF) << (8 * i));
    v.fwd = link ? v.pc + 32'd8 : v.alu;
    if (is_ld) begin
      val = v.rdata >> (8 * off);
      if (!aligned) v.reg_val = 0;
      else if (size == 1) v.reg_val = sgn ? 32'($signed(val[7:0])) : (val & 32'hFF);
      else if (size == 2) v.reg_val = sgn ? 32'($signed(val[15:0])) : (val & 32'hFFFF);
      else v.reg_val = val;
    end else begin
      v.reg_val = v.fwd;
    end
    v.err = (is_ld || is_st) && !aligned;
    v.wtnew = (v.tnew > 0) ? v.tnew - 3'd1 : 3'd0;
    if (v.clr) begin
      v.reg_val = 0; v.err = 0; v.wtnew = 0;
    end
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    clr = v.clr; M_Ins = v.ins; M_ALUAns = v.alu; M_WriteData = v.rt;
    M_PCAddr = v.pc; DM_RData = v.rdata; M_TargetReg = v.tr; M_T_new = v.tnew;
    #1;
    chk({tag, " DM_Addr"}, DM_Addr, v.alu & 32'hFFFF_FFFC);
    chk({tag, " DM_ByteEn"}, 32'(DM_ByteEn), 32'(v.be));
    if (v.chk_wd) chk({tag, " DM_WData"}, DM_WData, v.wd);
    chk({tag, " M_FwdData"}, M_FwdData, v.fwd);
    @(posedge clk);
    #1;
    chk({tag, " W_Ins"}, W_Ins, v.clr ? 32'h0 : v.ins);
    chk({tag, " W_TargetReg"}, 32'(W_TargetReg), v.clr ? 32'h0 : 32'(v.tr));
    chk({tag, " W_T_new"}, 32'(W_T_new), 32'(v.wtnew));
    chk({tag, " W_RegData"}, W_RegData, v.reg_val);
    chk({tag, " W_AddrErr"}, 32'(W_AddrErr), 32'(v.err));
    if (!v.clr) chk({tag, " W_PCAddr"}, W_PCAddr, v.pc);
  endtask

  task automatic chk_w_zero(input string tag);
    chk({tag, " W_Ins"}, W_Ins, 32'h0);
    chk({tag, " W_TargetReg"}, 32'(W_TargetReg), 32'h0);
    chk({tag, " W_T_new"}, 32'(W_T_new), 32'h0);
    chk({tag, " W_RegData"}, W_RegData, 32'h0);
    chk({tag, " W_PCAddr"}, W_PCAddr, 32'h0);
    chk({tag, " W_AddrErr"}, 32'(W_AddrErr), 32'h0);
  endtask

  vec_t tbl[$];
  vec_t rv;
  logic [31:0] r;
  logic [31:0] ops[11];

  initial begin
    //       clr ins        alu           rt            pc            rdata         tr  tn cw be    wd            fwd           reg           wtn err
    tbl.push_back(mk(0, I_SW | 32'h0085_0004, 32'h104, 32'hDEADBEEF, 32'h400, 32'h0, 0, 0, 1, 4'hF, 32'hDEADBEEF, 32'h104, 32'h104, 0, 0));
    tbl.push_back(mk(0, I_SB, 32'h103, 32'hA5, 32'h404, 32'h0, 0, 0, 1, 4'h8, 32'hA5A5A5A5, 32'h103, 32'h103, 0, 0));
    tbl.push_back(mk(0, I_LB, 32'h102, 32'h0, 32'h408, 32'h0080_0000, 5, 2, 0, 4'h0, 32'h0, 32'h102, 32'hFFFFFF80, 1, 0));
    tbl.push_back(mk(0, I_LBU, 32'h102, 32'h0, 32'h40C, 32'h0080_0000, 6, 1, 0, 4'h0, 32'h0, 32'h102, 32'h80, 0, 0));
    tbl.push_back(mk(0, I_JAL | 32'h0000_0C00, 32'h55, 32'h0, 32'h3000, 32'h0, 31, 0, 0, 4'h0, 32'h0, 32'h3008, 32'h3008, 0, 0));
    tbl.push_back(mk(0, I_LW, 32'h102, 32'h0, 32'h410, 32'h1234_5678, 2, 2, 0, 4'h0, 32'h0, 32'h102, 32'h0, 1, 1));
    tbl.push_back(mk(0, I_SH, 32'h102, 32'h1234, 32'h414, 32'h0, 0, 0, 1, 4'hC, 32'h12341234, 32'h102, 32'h102, 0, 0));
    tbl.push_back(mk(0, I_JALR, 32'h77, 32'h0, 32'hFFFFFFFC, 32'h0, 31, 0, 0, 4'h0, 32'h0, 32'h4, 32'h4, 0, 0));
    tbl.push_back(mk(0, I_LH, 32'h100, 32'h0, 32'h418, 32'h1234_8001, 3, 2, 0, 4'h0, 32'h0, 32'h100, 32'hFFFF8001, 1, 0));
    tbl.push_back(mk(0, I_LHU, 32'h103, 32'h0, 32'h41C, 32'hFFFF_FFFF, 3, 2, 0, 4'h0, 32'h0, 32'h103, 32'h0, 1, 1));
    tbl.push_back(mk(0, I_SW, 32'h101, 32'h11223344, 32'h420, 32'h0, 0, 0, 1, 4'h0, 32'h11223344, 32'h101, 32'h101, 0, 1));
    tbl.push_back(mk(0, 32'h0, 32'hABCD, 32'h0, 32'h424, 32'h0, 0, 2, 0, 4'h0, 32'h0, 32'hABCD, 32'hABCD, 1, 0));
    tbl.push_back(mk(1, I_SW, 32'h100, 32'h5, 32'h428, 32'h0, 7, 2, 1, 4'hF, 32'h5, 32'h100, 32'h0, 0, 0));
    tbl.push_back(mk(0, I_LW, 32'h200, 32'h0, 32'h42C, 32'hCAFEBABE, 8, 7, 0, 4'h0, 32'h0, 32'h200, 32'hCAFEBABE, 6, 0));
    tbl.push_back(mk(0, I_SB, 32'h100, 32'h12345678, 32'h430, 32'h0, 0, 0, 1, 4'h1, 32'h78787878, 32'h100, 32'h100, 0, 0));
    tbl.push_back(mk(0, I_LHU, 32'h102, 32'h0, 32'h434, 32'h8001_0000, 4, 0, 0, 4'h0, 32'h0, 32'h102, 32'h8001, 0, 0));
    tbl.push_back(mk(0, I_SH, 32'h103, 32'hBEEF, 32'h438, 32'h0, 0, 0, 1, 4'h0, 32'hBEEFBEEF, 32'h103, 32'h103, 0, 1));
    tbl.push_back(mk(1, I_LW, 32'h101, 32'h0, 32'h43C, 32'hFFFF_FFFF, 9, 3, 0, 4'h0, 32'h0, 32'h101, 32'h0, 0, 0));

    reset = 1'b0; clr = 1'b0; M_Ins = 0; M_TargetReg = 0; M_T_new = 0;
    M_ALUAns = 0; M_WriteData = 0; M_PCAddr = 0; DM_RData = 0;
    #3;
    chk_w_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Async reset between edges: W clears at once, combinational port keeps following inputs.
    apply(tbl[0], "pre_rst");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk_w_zero("async_rst");
    chk("async_rst DM_ByteEn", 32'(DM_ByteEn), 32'hF);
    @(negedge clk);
    reset = 1'b1;

    ops = '{I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW, I_JAL, 32'h0, 32'h2400_0000};
    for (int n = 0; n < 400; n++) begin
      int k;
      k = $urandom_range(0, 12);
      r = $urandom();
      if (k < 11) rv.ins = {ops[k][31:26], r[25:0]};
      else if (k == 11) rv.ins = {6'h00, r[25:6], 6'h09};
      else rv.ins = 32'h0;
      if (k == 9) rv.ins = {6'h00, r[25:6], 6'h21};
      if (n % 50 == 0) rv.ins = 32'h0;
      rv.clr = ($urandom_range(0, 7) == 0);
      rv.alu = $urandom(); rv.rt = $urandom(); rv.pc = $urandom(); rv.rdata = $urandom();
      r = $urandom();
      rv.tr = r[4:0]; rv.tnew = r[7:5];
      apply(model(rv), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
